// File: rtl/keypad_pkg.sv
// Shared types, key code constants and decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

    // Key code printed on the cap at (row, col).
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // Returns {hit, col}; hit only when exactly one column is pulled low.
    function automatic logic [2:0] classify_cols(input logic [3:0] cols);
        logic [2:0] res;
        case (cols)
            4'b1110: res = {1'b1, 2'd0};
            4'b1101: res = {1'b1, 2'd1};
            4'b1011: res = {1'b1, 2'd2};
            4'b0111: res = {1'b1, 2'd3};
            default: res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad columns.
module keypad_col_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_i,
    output logic [3:0] col_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Idle level is all-high (no key), so both stages reset to ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= col_i;
            sync_q <= meta_q;
        end
    end

    assign col_o = sync_q;

endmodule

// File: rtl/matrix_keypad_scanner.sv
// 4x4 keypad scanner: row multiplexing, debounce FSM, valid/ready key output and BCD entry register.
module matrix_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W     = 18,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        key_held,
    output logic        overflow,
    output logic [15:0] entry_bcd
);

    localparam int              CNT_W       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam bit              SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

    logic [SCAN_DIV_W-1:0] div_q;
    logic                  tick_s;
    logic [3:0]            col_s;
    logic [2:0]            sample_s;
    logic                  hit_s;
    logic [1:0]            hit_col_s;

    kp_state_e             state_q,    state_d;
    logic [1:0]            row_q,      row_d;
    logic [3:0]            row_out_q,  row_out_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [1:0]            cand_row_q, cand_row_d;
    logic [1:0]            cand_col_q, cand_col_d;
    logic                  key_held_q, key_held_d;
    logic                  advance_s;
    logic                  emit_s;
    logic [3:0]            emit_code_s;

    logic [3:0]            code_q,     code_d;
    logic                  valid_q,    valid_d;
    logic                  ovf_q,      ovf_d;
    logic [15:0]           entry_q,    entry_d;

    keypad_col_sync u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .col_i (col_in),
        .col_o (col_s)
    );

    // Free-running scan divider; the all-ones cycle closes each row period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + SCAN_DIV_W'(1);
        end
    end

    assign tick_s    = &div_q;
    assign sample_s  = classify_cols(col_s);
    assign hit_s     = sample_s[2];
    assign hit_col_s = sample_s[1:0];

    // Scan/debounce next-state logic; the row only moves while idle or on a rejected candidate.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        advance_s  = 1'b0;
        emit_s     = 1'b0;
        if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (hit_s) begin
                        cand_row_d = row_q;
                        cand_col_d = hit_col_s;
                        cnt_d      = CNT_ONE;
                        if (SINGLE_SCAN) begin
                            emit_s  = 1'b1;
                            state_d = ST_PRESSED;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        advance_s = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (hit_s && (hit_col_s == cand_col_q)) begin
                        if (cnt_q == CNT_LAST) begin
                            emit_s  = 1'b1;
                            state_d = ST_PRESSED;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d   = ST_IDLE;
                        advance_s = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!hit_s) begin
                        cnt_d = CNT_ONE;
                        if (SINGLE_SCAN) begin
                            state_d   = ST_IDLE;
                            advance_s = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_RELEASE: begin
                    if (hit_s) begin
                        state_d = ST_PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_IDLE;
                        advance_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (advance_s) begin
            row_d = row_q + 2'd1;
        end else begin
            row_d = row_q;
        end
        row_out_d   = ~(4'b0001 << row_d);
        emit_code_s = keymap(cand_row_d, cand_col_d);
        // A key stays "held" until its release has been debounced too.
        key_held_d  = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
    end

    // Scan FSM state and its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_q      <= 2'd0;
            row_out_q  <= 4'b1110;
            cnt_q      <= '0;
            cand_row_q <= 2'd0;
            cand_col_q <= 2'd0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            row_out_q  <= row_out_d;
            cnt_q      <= cnt_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            key_held_q <= key_held_d;
        end
    end

    // Handshake and entry register; a key arriving into a full slot is dropped but still entered.
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        entry_d = entry_q;
        if (emit_s) begin
            if (!valid_q || key_ready) begin
                code_d  = emit_code_s;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
            if (emit_code_s <= KEY_MAX_DIGIT) begin
                entry_d = {entry_q[11:0], emit_code_s};
            end else if (emit_code_s == KEY_STAR) begin
                entry_d = 16'h0000;
            end else begin
                entry_d = entry_q;
            end
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output key slot, sticky overflow and BCD entry digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            entry_q <= 16'h0000;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            entry_q <= entry_d;
        end
    end

    assign row_out   = row_out_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = key_held_q;
    assign overflow  = ovf_q;
    assign entry_bcd = entry_q;

endmodule
